// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and grant-select constants for the memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data ports.
// MEM_ARB_RR_EN selects round-robin on contention; default is fixed data priority.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic gnt
);

`ifdef MEM_ARB_RR_EN
  // On contention favour whichever port was not served last.
  always_comb begin
    gnt = GNT_IF;
    if (if_req && d_req) begin
      gnt = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
    end else if (d_req) begin
      gnt = GNT_D;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = last_gnt ^ if_req;
  assign gnt = d_req ? GNT_D : GNT_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single ready-handshake memory.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t             state;
  logic               gnt_q;
  logic               gnt;
  logic               last_gnt;
  logic [CNT_W-1:0]   cnt;
  logic               any_req;

  assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  // Remembers the most recent grant; resets to fetch so data wins first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= GNT_IF;
    end else if (state == IDLE && any_req) begin
      last_gnt <= gnt;
    end
  end
`else
  assign last_gnt = GNT_IF;
`endif

  mem_arb_pick u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  // Access sequencer: grant, wait for ready or timeout, one-cycle done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt_q     <= GNT_IF;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= gnt;
            cnt     <= '0;
            mem_req <= 1'b1;
            state   <= BUSY;
            if (gnt == GNT_D) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            err     <= 1'b0;
            state   <= RESP;
            if (gnt_q == GNT_D) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            // This stalled cycle brings the count to TIMEOUT: abort the access.
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              mem_req <= 1'b0;
              err     <= 1'b1;
              state   <= RESP;
              if (gnt_q == GNT_D) begin
                d_rdata <= '0;
                d_done  <= 1'b1;
              end else begin
                if_rdata <= '0;
                if_done  <= 1'b1;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4); honours MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_d_rdata  = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          waits;
    logic [31:0] rdata;
    logic        exp_d;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Entered at the negedge of an IDLE cycle with requests already driven.
  task automatic access(input logic exp_d, input logic [31:0] exp_addr, input logic exp_we,
                        input logic [31:0] exp_wdata, input int waits, input logic [31:0] rdata,
                        input logic drop, input logic inject);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i <= waits; i++) begin
      chk("busy_mem_req", 64'(mem_req), 64'(1));
      chk("busy_mem_addr", 64'(mem_addr), 64'(exp_addr));
      chk("busy_mem_we", 64'(mem_we), 64'(exp_we));
      if (exp_we) chk("busy_mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      chk("busy_no_done", 64'({if_done, d_done}), 64'(0));
      if (inject && i == 0) begin
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h5555AAAA;
      end
      if (i == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    if (exp_d) exp_d_rdata = rdata;
    else exp_if_rdata = rdata;
    chk("if_done", 64'(if_done), 64'(!exp_d));
    chk("d_done", 64'(d_done), 64'(exp_d));
    chk("err_ok", 64'(err), 64'(0));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    chk("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
    chk("resp_mem_req", 64'(mem_req), 64'(0));
    if (drop) begin
      if (exp_d) d_req = 1'b0;
      else if_req = 1'b0;
    end
    @(negedge clk);
    chk("done_one_cycle", 64'({if_done, d_done}), 64'(0));
    chk("idle_mem_req", 64'(mem_req), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_c[3];
    vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        2, 32'h00500093, 1'b0};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 3, 32'h11111111, 1'b1};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h80, 32'h0,        0, 32'hCAFEF00D, 1'b1};
    vecs[3] = '{1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,        1, 32'h12345678, 1'b0};

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem", 64'({mem_req, mem_we}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_done_err", 64'({if_done, d_done, err}), 64'(0));
    chk("rst_rdata", {if_rdata, d_rdata}, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single-port table: fetch, store, zero-wait load, fetch.
    for (int k = 0; k < 4; k++) begin
      if_req = vecs[k].if_req; if_addr = vecs[k].if_addr;
      d_req = vecs[k].d_req; d_we = vecs[k].d_we;
      d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
      access(vecs[k].exp_d, vecs[k].exp_d ? vecs[k].d_addr : vecs[k].if_addr,
             vecs[k].exp_d & vecs[k].d_we, vecs[k].d_wdata, vecs[k].waits,
             vecs[k].rdata, 1'b1, 1'b0);
    end

    // Data request raised mid-fetch must wait until IDLE, then be served.
    if_req = 1'b1; if_addr = 32'h20;
    access(1'b0, 32'h20, 1'b0, 32'h0, 2, 32'h0A0A0A0A, 1'b1, 1'b1);
    access(1'b1, 32'h200, 1'b1, 32'h5555AAAA, 1, 32'h77777777, 1'b1, 1'b0);

    // Timeout: ready never comes.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_req", 64'(mem_req), 64'(1));
      chk("to_no_done", 64'({if_done, d_done}), 64'(0));
      @(negedge clk);
    end
    exp_d_rdata = '0;
    chk("to_d_done", 64'({if_done, d_done}), 64'(1));
    chk("to_err", 64'(err), 64'(1));
    chk("to_d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
    chk("to_if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    chk("to_mem_req_low", 64'(mem_req), 64'(0));
    d_req = 1'b0;
    @(negedge clk);
    chk("to_done_one_cycle", 64'(d_done), 64'(0));

    // Ready on the last allowed cycle completes normally and clears err.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
    access(1'b1, 32'h304, 1'b0, 32'h0, 3, 32'h13579BDF, 1'b1, 1'b0);

    // Reset in the second BUSY cycle abandons the fetch.
    if_req = 1'b1; if_addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    chk("rb_busy1", 64'(mem_req), 64'(1));
    @(negedge clk);
    chk("rb_busy2", 64'(mem_req), 64'(1));
    reset = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("rb_mem_req", 64'(mem_req), 64'(0));
    chk("rb_no_done", 64'({if_done, d_done}), 64'(0));
    reset = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
    chk("rb_idle_no_done", 64'({if_done, d_done, mem_req}), 64'(0));
    chk("rb_rdata_clr", {if_rdata, d_rdata}, 64'(0));

    // Back-to-back contention with both requests held.
`ifdef MEM_ARB_RR_EN
    exp_c = '{1'b1, 1'b0, 1'b1};
`else
    exp_c = '{1'b1, 1'b1, 1'b1};
`endif
    if_req = 1'b1; if_addr = 32'h600;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    for (int k = 0; k < 3; k++) begin
      access(exp_c[k], exp_c[k] ? 32'h700 : 32'h600, 1'b0, 32'h0, 1,
             32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("final_idle", 64'({if_done, d_done, mem_req}), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for mem_ready before an access aborts.
REQ-004 SHALL have ports, one per line:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  instruction-fetch request, level
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data
if_done  out  1  fetch complete, one-cycle pulse
d_req  in  1  data request, level
d_we  in  1  data write enable (1 store, 0 load)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data
d_done  out  1  data complete, one-cycle pulse
err  out  1  completing access timed out, valid with if_done/d_done
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory access complete this cycle

Function
REQ-005 SHALL implement a state machine with states IDLE, BUSY, RESP.
REQ-006 IDLE: if any request is high, SHALL grant one, latch its address, write enable, and write data, and go to BUSY; otherwise SHALL stay in IDLE.
REQ-007 Fixed priority (no macro): d_req SHALL win over if_req when both are high.
REQ-008 Fetch grants SHALL drive mem_we=0; data grants SHALL drive mem_we=d_we.
REQ-009 BUSY: mem_req SHALL be 1, and mem_addr, mem_we, mem_wdata SHALL hold the latched values, stable until exit.
REQ-010 BUSY with mem_ready=1: SHALL capture mem_rdata into the granted port's rdata register, set err=0, and go to RESP.
REQ-011 BUSY: a wait counter SHALL clear on entry and increment each cycle mem_ready=0.
REQ-012 When the counter reaches TIMEOUT with mem_ready=0, SHALL drop mem_req, load rdata with 0, set err=1, and go to RESP.
REQ-013 RESP: SHALL assert the granted port's done for exactly one cycle, make no new grant, and return to IDLE.
REQ-014 Latency: request sampled at edge t gives mem_req high in cycle t+1; mem_ready sampled at edge u gives done high in cycle u+1.
REQ-015 Requesters SHALL hold req and operands until their done; they drop req at the edge ending the done cycle, so IDLE never re-grants a completed access.
REQ-016 if_rdata and d_rdata SHALL hold their last value until the next completion for that port.
REQ-017 if_done and d_done SHALL never be high in the same cycle.
REQ-018 Requests arriving or changing during BUSY/RESP SHALL be ignored until IDLE.
REQ-019 mem_req SHALL be 0 in IDLE and RESP.

Reset
REQ-020 Reset SHALL force IDLE and clear the counter, mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done, err, if_rdata, and d_rdata to 0.
REQ-021 Reset during BUSY SHALL abandon the access with no done pulse; mem_req SHALL be 0 in the following cycle.

Configuration
REQ-022 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on contention, grant the port not granted last; the last-grant bit resets to "fetch", so data wins the first contention.
REQ-023 Without MEM_ARB_RR_EN, arbitration SHALL be fixed data-priority per REQ-007, with no last-grant state.

Structure
REQ-024 Shared package SHALL hold the state encoding (IDLE=0, BUSY=1, RESP=2) and the grant-select constants (GNT_IF=0, GNT_D=1).
REQ-025 Arbitration SHALL be a sub-module mem_arb_pick (inputs if_req, d_req, last_gnt; output gnt); all else lives in mem_arbiter.

Verification
REQ-026 Fetch only: if_req=1, if_addr=0x10; mem_ready after 2 BUSY cycles with mem_rdata=0x00500093 -> if_done pulse, if_rdata=0x00500093, err=0.
REQ-027 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF held until mem_ready; d_done pulse.
REQ-028 Contention: if_req and d_req high together for back-to-back accesses -> fixed build: data, data, ...; MEM_ARB_RR_EN build: data, fetch, data.
REQ-029 Timeout: TIMEOUT=4, mem_ready held 0 -> mem_req high 4 cycles, then d_done=1, err=1, d_rdata=0.
REQ-030 Reset mid-BUSY: reset asserted in the second BUSY cycle -> next cycle IDLE, mem_req=0, no done pulse.
REQ-031 Zero-wait memory: mem_ready=1 in the first BUSY cycle -> done exactly 2 cycles after the request sample edge.
